// File: rtl/alu_exec_unit.sv
// Multi-cycle integer ALU: collects rs1/rs2 operands, then executes in one cycle
// or, for non-zero shifts, shifts one bit per cycle.
module alu_exec_unit #(
    parameter int unsigned BUS_WIDTH    = 32,
    parameter int unsigned OPCODE_WIDTH = 11,
    parameter int unsigned SHAMT_WIDTH  = $clog2(BUS_WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [BUS_WIDTH-1:0]    imme_value,
    input  logic [BUS_WIDTH-1:0]    rs_data,
    input  logic                    rs_data_sel,
    input  logic                    rs_data_valid,
    input  logic [OPCODE_WIDTH-1:0] op_code,
    output logic [BUS_WIDTH-1:0]    alu_out,
    output logic                    alu_valid_out,
    output logic                    op_done,
    output logic                    busy,
    output logic                    illegal_op
);

    localparam logic [6:0] OPC_R = 7'b0110011;
    localparam logic [6:0] OPC_I = 7'b0010011;

    typedef enum logic [1:0] {IDLE, EXEC, SHIFT} state_t;

    state_t                  state;
    state_t                  state_n;
    logic [BUS_WIDTH-1:0]    rs1;
    logic [BUS_WIDTH-1:0]    rs2;
    logic                    rs1_ok;
    logic                    rs2_ok;
    logic [OPCODE_WIDTH-1:0] op_q;
    logic [BUS_WIDTH-1:0]    opa;
    logic [BUS_WIDTH-1:0]    opb;
    logic [SHAMT_WIDTH-1:0]  cnt;
    logic                    illegal_q;

    logic [BUS_WIDTH-1:0]    alu_out_n;
    logic                    alu_valid_n;
    logic                    op_done_n;
    logic                    illegal_n;

    // Incoming operand / op_code decode (only meaningful in IDLE)
    logic                   ld;
    logic                   rs1_ok_nx;
    logic                   rs2_ok_nx;
    logic                   in_is_r;
    logic                   in_is_i;
    logic                   in_illegal;
    logic                   capture;
    logic                   goes_shift;
    logic [BUS_WIDTH-1:0]   src_a;
    logic [BUS_WIDTH-1:0]   src_b;
    logic [SHAMT_WIDTH-1:0] in_shamt;
    logic [2:0]             in_f3;

    assign ld         = (state == IDLE) && rs_data_valid;
    assign rs1_ok_nx  = rs1_ok | (ld & ~rs_data_sel);
    assign rs2_ok_nx  = rs2_ok | (ld & rs_data_sel);
    assign in_is_r    = (op_code[6:0] == OPC_R);
    assign in_is_i    = (op_code[6:0] == OPC_I);
    assign in_f3      = op_code[9:7];
    assign src_a      = (ld && !rs_data_sel) ? rs_data : rs1;
    assign src_b      = in_is_i ? imme_value : ((ld && rs_data_sel) ? rs_data : rs2);
    assign in_shamt   = src_b[SHAMT_WIDTH-1:0];
    // SRLI must have a clean immediate above the shift amount
    assign in_illegal = (!in_is_r && !in_is_i) ||
                        (in_is_i && (in_f3 == 3'b101) && !op_code[10] &&
                         (|imme_value[BUS_WIDTH-1:SHAMT_WIDTH]));
    assign capture    = ld && ((in_is_r && rs1_ok_nx && rs2_ok_nx) ||
                               (in_is_i && rs1_ok_nx) ||
                               (!in_is_r && !in_is_i));
    assign goes_shift = !in_illegal && ((in_f3 == 3'b001) || (in_f3 == 3'b101)) &&
                        (in_shamt != '0);

    // Latched-op decode for EXEC/SHIFT
    logic [2:0]           f3_q;
    logic                 f7_q;
    logic                 is_r_q;
    logic [BUS_WIDTH-1:0] shift_one;
    logic [BUS_WIDTH-1:0] exec_result;

    assign f3_q   = op_q[9:7];
    assign f7_q   = op_q[10];
    assign is_r_q = (op_q[6:0] == OPC_R);

    always_comb begin
        shift_one = {opa[BUS_WIDTH-2:0], 1'b0};
        if (f3_q == 3'b101) begin
            shift_one = {(f7_q ? opa[BUS_WIDTH-1] : 1'b0), opa[BUS_WIDTH-1:1]};
        end
    end

    // Shifts only reach EXEC with a zero shift amount, so they pass operand A through
    always_comb begin
        exec_result = '0;
        case (f3_q)
            3'b000:  exec_result = (is_r_q && f7_q) ? (opa - opb) : (opa + opb);
            3'b010:  exec_result = BUS_WIDTH'($signed(opa) < $signed(opb));
            3'b011:  exec_result = BUS_WIDTH'(opa < opb);
            3'b100:  exec_result = opa ^ opb;
            3'b110:  exec_result = opa | opb;
            3'b111:  exec_result = opa & opb;
            default: exec_result = opa;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (capture) state_n = goes_shift ? SHIFT : EXEC;
            EXEC:    state_n = IDLE;
            SHIFT:   if (cnt == SHAMT_WIDTH'(1)) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        alu_out_n   = alu_out;
        alu_valid_n = 1'b0;
        op_done_n   = 1'b0;
        illegal_n   = 1'b0;
        busy        = (state != IDLE);
        case (state)
            EXEC: begin
                op_done_n = 1'b1;
                if (illegal_q) begin
                    illegal_n = 1'b1;
                end else begin
                    alu_valid_n = 1'b1;
                    alu_out_n   = exec_result;
                end
            end
            SHIFT: begin
                if (cnt == SHAMT_WIDTH'(1)) begin
                    op_done_n   = 1'b1;
                    alu_valid_n = 1'b1;
                    alu_out_n   = shift_one;
                end
            end
            default: ;
        endcase
    end

    // Operand collection, op latch and shift datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs1       <= '0;
            rs2       <= '0;
            rs1_ok    <= 1'b0;
            rs2_ok    <= 1'b0;
            op_q      <= '0;
            opa       <= '0;
            opb       <= '0;
            cnt       <= '0;
            illegal_q <= 1'b0;
        end else begin
            if (ld) begin
                if (rs_data_sel) rs2 <= rs_data;
                else             rs1 <= rs_data;
            end
            if (capture) begin
                rs1_ok    <= 1'b0;
                rs2_ok    <= 1'b0;
                op_q      <= op_code;
                opa       <= src_a;
                opb       <= src_b;
                cnt       <= in_shamt;
                illegal_q <= in_illegal;
            end else if (ld) begin
                rs1_ok <= rs1_ok_nx;
                rs2_ok <= rs2_ok_nx;
            end
            if (state == SHIFT) begin
                opa <= shift_one;
                cnt <= cnt - SHAMT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_out       <= '0;
            alu_valid_out <= 1'b0;
            op_done       <= 1'b0;
            illegal_op    <= 1'b0;
        end else begin
            alu_out       <= alu_out_n;
            alu_valid_out <= alu_valid_n;
            op_done       <= op_done_n;
            illegal_op    <= illegal_n;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: hand-computed results, latency, illegal ops and reset.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imme_value;
    logic [31:0] rs_data;
    logic        rs_data_sel;
    logic        rs_data_valid;
    logic [10:0] op_code;
    logic [31:0] alu_out;
    logic        alu_valid_out;
    logic        op_done;
    logic        busy;
    logic        illegal_op;

    int total = 0;
    int bad   = 0;

    localparam logic [6:0] R = 7'b0110011;
    localparam logic [6:0] I = 7'b0010011;

    alu_exec_unit dut (
        .clk           (clk),
        .rst           (rst),
        .imme_value    (imme_value),
        .rs_data       (rs_data),
        .rs_data_sel   (rs_data_sel),
        .rs_data_valid (rs_data_valid),
        .op_code       (op_code),
        .alu_out       (alu_out),
        .alu_valid_out (alu_valid_out),
        .op_done       (op_done),
        .busy          (busy),
        .illegal_op    (illegal_op)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic sel, input logic [31:0] d, input logic [10:0] op,
                        input logic [31:0] imm);
        rs_data_sel   = sel;
        rs_data       = d;
        op_code       = op;
        imme_value    = imm;
        rs_data_valid = 1'b1;
        step();
        rs_data_valid = 1'b0;
    endtask

    // Called one sample point after the capture edge
    task automatic expect_result(input string tag, input int lat, input logic [31:0] exp,
                                 input logic poke);
        for (int i = 0; i < lat; i++) begin
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            chk({tag, "_early"}, 32'(alu_valid_out), 32'd0);
            if (poke) begin
                rs_data_valid = 1'b1;
                rs_data_sel   = 1'b0;
                rs_data       = 32'hDEAD_BEEF;
            end
            step();
        end
        rs_data_valid = 1'b0;
        chk({tag, "_valid"}, 32'(alu_valid_out), 32'd1);
        chk({tag, "_done"}, 32'(op_done), 32'd1);
        chk({tag, "_ill"}, 32'(illegal_op), 32'd0);
        chk({tag, "_busyoff"}, 32'(busy), 32'd0);
        chk(tag, alu_out, exp);
    endtask

    task automatic run_r(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [10:0] op, input int lat, input logic [31:0] exp);
        send(1'b0, a, op, 32'h0);
        chk({tag, "_wait"}, 32'(busy), 32'd0);
        send(1'b1, b, op, 32'h0);
        expect_result(tag, lat, exp, 1'b0);
    endtask

    task automatic run_i(input string tag, input logic [31:0] a, input logic [31:0] imm,
                         input logic [10:0] op, input int lat, input logic [31:0] exp,
                         input logic poke);
        send(1'b0, a, op, imm);
        expect_result(tag, lat, exp, poke);
    endtask

    initial begin
        int vcount;
        rst           = 1'b1;
        imme_value    = '0;
        rs_data       = '0;
        rs_data_sel   = 1'b0;
        rs_data_valid = 1'b0;
        op_code       = '0;
        step();
        chk("rst_out", alu_out, 32'h0);
        chk("rst_valid", 32'(alu_valid_out), 32'd0);
        chk("rst_done", 32'(op_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ill", 32'(illegal_op), 32'd0);
        rst = 1'b0;

        run_r("add", 32'h5, 32'h7, {1'b0, 3'b000, R}, 1, 32'h0000_000C);
        step();
        chk("add_pulse_valid", 32'(alu_valid_out), 32'd0);
        chk("add_pulse_done", 32'(op_done), 32'd0);
        chk("add_hold", alu_out, 32'h0000_000C);

        // Back-to-back: each run starts in the op_done cycle of the previous one
        run_r("sub", 32'h3, 32'h5, {1'b1, 3'b000, R}, 1, 32'hFFFF_FFFE);
        run_r("slt", 32'h3, 32'h5, {1'b0, 3'b010, R}, 1, 32'h1);
        run_r("sltu", 32'hFFFF_FFFF, 32'h1, {1'b0, 3'b011, R}, 1, 32'h0);
        run_r("slt_neg", 32'hFFFF_FFFF, 32'h1, {1'b0, 3'b010, R}, 1, 32'h1);
        run_r("xor", 32'hF0F0_1234, 32'h0FF0_00FF, {1'b0, 3'b100, R}, 1, 32'hFF00_12CB);
        run_r("or", 32'hF0F0_1234, 32'h0FF0_00FF, {1'b0, 3'b110, R}, 1, 32'hFFF0_12FF);
        run_r("and", 32'hF0F0_1234, 32'h0FF0_00FF, {1'b0, 3'b111, R}, 1, 32'h00F0_0034);
        run_r("add_wrap", 32'hFFFF_FFFF, 32'h2, {1'b0, 3'b000, R}, 1, 32'h1);
        run_r("sll_r", 32'h3, 32'h1, {1'b0, 3'b001, R}, 1, 32'h6);
        run_r("sra_r_shamt_mask", 32'h0000_00F0, 32'h24, {1'b1, 3'b101, R}, 4, 32'h0000_000F);

        run_i("addi", 32'hA, 32'hFFFF_FFFF, {1'b0, 3'b000, I}, 1, 32'h9, 1'b0);
        run_i("srai", 32'h8000_0000, 32'h404, {1'b1, 3'b101, I}, 4, 32'hF800_0000, 1'b1);

        // Loads while busy must not have set rs1_ok: an rs2 load alone must not start ADDI
        send(1'b1, 32'h99, {1'b0, 3'b000, I}, 32'h1);
        chk("ignore_busy_load", 32'(busy), 32'd0);
        run_i("addi2", 32'h20, 32'h1, {1'b0, 3'b000, I}, 1, 32'h21, 1'b0);

        run_i("srli", 32'h8000_0000, 32'h4, {1'b0, 3'b101, I}, 4, 32'h0800_0000, 1'b0);
        run_i("slli0", 32'h1234_5678, 32'h0, {1'b0, 3'b001, I}, 1, 32'h1234_5678, 1'b0);

        send(1'b0, 32'h5, {1'b0, 3'b000, 7'b1111111}, 32'h0);
        chk("illop_busy", 32'(busy), 32'd1);
        step();
        chk("illop_done", 32'(op_done), 32'd1);
        chk("illop_flag", 32'(illegal_op), 32'd1);
        chk("illop_valid", 32'(alu_valid_out), 32'd0);
        chk("illop_hold", alu_out, 32'h1234_5678);
        step();
        chk("illop_pulse", 32'(illegal_op), 32'd0);

        send(1'b0, 32'h5, {1'b0, 3'b101, I}, 32'h404);
        step();
        chk("badsrli_flag", 32'(illegal_op), 32'd1);
        chk("badsrli_valid", 32'(alu_valid_out), 32'd0);
        chk("badsrli_hold", alu_out, 32'h1234_5678);

        // Reset in the second SHIFT cycle of a 31-bit shift
        send(1'b0, 32'h1, {1'b0, 3'b001, I}, 32'd31);
        step();
        chk("rs_midshift_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("rs_out", alu_out, 32'h0);
        chk("rs_busy", 32'(busy), 32'd0);
        chk("rs_valid", 32'(alu_valid_out), 32'd0);
        chk("rs_done", 32'(op_done), 32'd0);
        chk("rs_ill", 32'(illegal_op), 32'd0);
        step();
        rst = 1'b0;
        vcount = 0;
        for (int i = 0; i < 35; i++) begin
            step();
            if (alu_valid_out || op_done || busy) vcount++;
        end
        chk("rs_no_pulse", 32'(vcount), 32'd0);

        run_i("post_rst_addi", 32'h3, 32'h4, {1'b0, 3'b000, I}, 1, 32'h7, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
